// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if
//   Bundles the sample handshake and the queue/FIR control signals of the
//   FIR equalizer scheduler.
//   master : codec/sample side (drives smpl_vld, clr_err, observes status)
//   slave  : fir_seq_ctrl (drives queue and burst control)
//   Signals: smpl_vld, clr_err, wrt_smpl, wr_ptr[AW], rd_ptr[AW], sequencing,
//            out_vld, busy, full, overrun, drop_cnt[8] (only with
//            FIR_SEQ_DROP_CNT_EN defined).
interface fir_seq_ctrl_if #(
  parameter int AW = 11
);
  logic          smpl_vld;
  logic          clr_err;
  logic          wrt_smpl;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          sequencing;
  logic          out_vld;
  logic          busy;
  logic          full;
  logic          overrun;
`ifdef FIR_SEQ_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  modport master (
`ifdef FIR_SEQ_DROP_CNT_EN
    input  drop_cnt,
`endif
    output smpl_vld, clr_err,
    input  wrt_smpl, wr_ptr, rd_ptr, sequencing, out_vld, busy, full, overrun
  );

  modport slave (
`ifdef FIR_SEQ_DROP_CNT_EN
    output drop_cnt,
`endif
    input  smpl_vld, clr_err,
    output wrt_smpl, wr_ptr, rd_ptr, sequencing, out_vld, busy, full, overrun
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl
//   Scheduler for the FIR equalizer datapath. Accepted samples are written
//   into a circular queue of DEPTH entries; once TAPS samples have arrived,
//   every accepted sample launches a TAPS-cycle burst that walks the queue
//   from the oldest to the newest sample, followed by a one-cycle out_vld.
//   Samples arriving while a burst (or its DONE cycle) is in progress are
//   dropped and flagged in the sticky overrun bit.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : fir_seq_ctrl_if.slave (smpl_vld/clr_err in; queue and burst
//          control, busy/full/overrun status out)
// Optional feature:
//   FIR_SEQ_DROP_CNT_EN : adds the saturating 8-bit drop counter drop_cnt.
// Parameters: TAPS (2..DEPTH), DEPTH (any value), AW (2^AW >= DEPTH).
module fir_seq_ctrl #(
  parameter int TAPS  = 1021,
  parameter int DEPTH = 1536,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  fir_seq_ctrl_if.slave bus
);

  localparam int FW = $clog2(TAPS + 1);
  localparam int TW = $clog2(TAPS);

  localparam logic [AW-1:0] ZERO_A  = AW'(0);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] TM1_A   = AW'(TAPS - 1);
  localparam logic [AW-1:0] BACK_A  = AW'(DEPTH - (TAPS - 1));
  localparam logic [FW-1:0] ZERO_F  = FW'(0);
  localparam logic [FW-1:0] ONE_F   = FW'(1);
  localparam logic [FW-1:0] TAPS_F  = FW'(TAPS);
  localparam logic [TW-1:0] ZERO_T  = TW'(0);
  localparam logic [TW-1:0] ONE_T   = TW'(1);
  localparam logic [TW-1:0] LAST_T  = TW'(TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FW-1:0] fill_r;
  logic [TW-1:0] tap_r;
  logic          overrun_r;

  logic          wrt_smpl_s, drop_s, seq_start_s;
  logic [AW-1:0] wr_nxt_s, rd_nxt_s, rd_load_s;
  logic [FW-1:0] fill_post_s;
  logic          sequencing_s, out_vld_s, busy_s;

  // Write qualification, pointer wrap and burst start address.
  always_comb begin
    wrt_smpl_s  = bus.smpl_vld && (state_r == ST_IDLE) && !rst;
    drop_s      = bus.smpl_vld && (state_r != ST_IDLE);
    wr_nxt_s    = (wr_ptr_r == LAST_A) ? ZERO_A : (wr_ptr_r + ONE_A);
    rd_nxt_s    = (rd_ptr_r == LAST_A) ? ZERO_A : (rd_ptr_r + ONE_A);
    // Oldest sample sits TAPS-1 entries behind the one just written.
    if (wr_ptr_r >= TM1_A) begin
      rd_load_s = wr_ptr_r - TM1_A;
    end else begin
      rd_load_s = wr_ptr_r + BACK_A;
    end
    fill_post_s = (fill_r == TAPS_F) ? TAPS_F : (fill_r + ONE_F);
    seq_start_s = wrt_smpl_s && (fill_post_s == TAPS_F);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (seq_start_s) begin
          state_nxt_s = ST_SEQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEQ: begin
        if (tap_r == LAST_T) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SEQ;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    sequencing_s = 1'b0;
    out_vld_s    = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_SEQ: begin
        sequencing_s = 1'b1;
        busy_s       = 1'b1;
      end
      ST_DONE: begin
        out_vld_s = 1'b1;
        busy_s    = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Queue pointers, fill count and tap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= ZERO_A;
      rd_ptr_r <= ZERO_A;
      fill_r   <= ZERO_F;
      tap_r    <= ZERO_T;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wrt_smpl_s) begin
            wr_ptr_r <= wr_nxt_s;
            fill_r   <= fill_post_s;
          end
          if (seq_start_s) begin
            rd_ptr_r <= rd_load_s;
            tap_r    <= ZERO_T;
          end
        end
        ST_SEQ: begin
          // rd_ptr holds on the final tap so it still shows W afterwards.
          if (tap_r == LAST_T) begin
            tap_r <= ZERO_T;
          end else begin
            tap_r    <= tap_r + ONE_T;
            rd_ptr_r <= rd_nxt_s;
          end
        end
        ST_DONE: begin
          tap_r <= ZERO_T;
        end
        default: begin
          tap_r <= ZERO_T;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new drop wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (bus.clr_err) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

`ifdef FIR_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating drop counter; a drop coinciding with clr_err counts as the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && bus.clr_err) begin
      drop_cnt_r <= 8'd1;
    end else if (bus.clr_err) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.drop_cnt = drop_cnt_r;
`endif

  assign bus.wrt_smpl   = wrt_smpl_s;
  assign bus.wr_ptr     = wr_ptr_r;
  assign bus.rd_ptr     = rd_ptr_r;
  assign bus.sequencing = sequencing_s;
  assign bus.out_vld    = out_vld_s;
  assign bus.busy       = busy_s;
  assign bus.full       = (fill_r == TAPS_F);
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl
//   Self-checking bench for fir_seq_ctrl with TAPS=4, DEPTH=6. A timing-window
//   model (sample count, burst start cycle, newest address) predicts every
//   output each cycle; directed sequences pin the model with literal values.
module tb_fir_seq_ctrl;
  localparam int TAPS  = 4;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.AW(AW)) bus_if ();

  fir_seq_ctrl #(.TAPS(TAPS), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: checks all outputs on every falling edge.
  initial begin : model
    int cyc, nwr, b_start, b_w, dcnt, k, w;
    bit ovr, seq_e, busy_e, ov_e, wrt_e, drop;
    cyc = 0; nwr = 0; b_start = -100; b_w = 0; dcnt = 0; ovr = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        chk("m_rst_wrt",  int'(bus_if.wrt_smpl), 0);
        chk("m_rst_seq",  int'(bus_if.sequencing), 0);
        chk("m_rst_busy", int'(bus_if.busy), 0);
        chk("m_rst_ov",   int'(bus_if.out_vld), 0);
        chk("m_rst_wr",   int'(bus_if.wr_ptr), 0);
        chk("m_rst_rd",   int'(bus_if.rd_ptr), 0);
        chk("m_rst_full", int'(bus_if.full), 0);
        chk("m_rst_ovr",  int'(bus_if.overrun), 0);
        nwr = 0; b_start = -100; ovr = 1'b0; dcnt = 0;
      end else begin
        k      = cyc - b_start;
        seq_e  = (k >= 0) && (k < TAPS);
        busy_e = (k >= 0) && (k <= TAPS);
        ov_e   = (k == TAPS);
        wrt_e  = bus_if.smpl_vld && !busy_e;
        drop   = bus_if.smpl_vld && busy_e;
        chk("m_wrt",  int'(bus_if.wrt_smpl), int'(wrt_e));
        chk("m_seq",  int'(bus_if.sequencing), int'(seq_e));
        chk("m_busy", int'(bus_if.busy), int'(busy_e));
        chk("m_ovld", int'(bus_if.out_vld), int'(ov_e));
        chk("m_wr",   int'(bus_if.wr_ptr), nwr % DEPTH);
        chk("m_full", int'(bus_if.full), int'(nwr >= TAPS));
        chk("m_ovr",  int'(bus_if.overrun), int'(ovr));
`ifdef FIR_SEQ_DROP_CNT_EN
        chk("m_dcnt", int'(bus_if.drop_cnt), dcnt);
`endif
        if (seq_e) begin
          chk("m_rd", int'(bus_if.rd_ptr), (b_w + DEPTH - (TAPS - 1) + k) % DEPTH);
        end else if (b_start < 0) begin
          chk("m_rd0", int'(bus_if.rd_ptr), 0);
        end
        if (wrt_e) begin
          w = nwr % DEPTH;
          nwr++;
          if (nwr >= TAPS) begin
            b_start = cyc + 1;
            b_w     = w;
          end
        end
        if (drop) ovr = 1'b1;
        else if (bus_if.clr_err) ovr = 1'b0;
        if (drop && bus_if.clr_err) dcnt = 1;
        else if (bus_if.clr_err) dcnt = 0;
        else if (drop && dcnt < 255) dcnt++;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int exp_wr, input string name);
    bus_if.smpl_vld = 1'b1;
    #1;
    chk({name, "_wrt"}, int'(bus_if.wrt_smpl), 1);
    chk({name, "_wrp"}, int'(bus_if.wr_ptr), exp_wr);
    @(posedge clk);
    #1;
    bus_if.smpl_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_if.busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_wait", int'(bus_if.busy), 0);
  endtask

  task automatic check_burst(input int exp_rd[4], input string name);
    for (int i = 0; i < 4; i++) begin
      chk({name, "_seq"},  int'(bus_if.sequencing), 1);
      chk({name, "_busy"}, int'(bus_if.busy), 1);
      chk({name, "_rd"},   int'(bus_if.rd_ptr), exp_rd[i]);
      tick();
    end
    chk({name, "_ovld"},  int'(bus_if.out_vld), 1);
    chk({name, "_dbusy"}, int'(bus_if.busy), 1);
    chk({name, "_dseq"},  int'(bus_if.sequencing), 0);
    tick();
    chk({name, "_end_busy"}, int'(bus_if.busy), 0);
    chk({name, "_end_ovld"}, int'(bus_if.out_vld), 0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Directed then randomized stimulus.
  initial begin
    bus_if.smpl_vld = 1'b0;
    bus_if.clr_err  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wr",   int'(bus_if.wr_ptr), 0);
    chk("rst_full", int'(bus_if.full), 0);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_ovr",  int'(bus_if.overrun), 0);

    pulse(0, "p1"); tick();
    pulse(1, "p2"); tick();
    pulse(2, "p3"); tick();
    chk("p3_seq",  int'(bus_if.sequencing), 0);
    chk("p3_full", int'(bus_if.full), 0);
    pulse(3, "p4");
    chk("p4_full", int'(bus_if.full), 1);
    check_burst('{0, 1, 2, 3}, "b1");

    pulse(4, "p5"); wait_idle(); tick();
    pulse(5, "p6"); wait_idle(); tick();
    pulse(0, "p7");
    check_burst('{3, 4, 5, 0}, "b7");

    // Drop during burst, then clr_err with a simultaneous drop.
    pulse(1, "p8");
    tick();
    bus_if.smpl_vld = 1'b1;
    #1;
    chk("drop_wrt", int'(bus_if.wrt_smpl), 0);
    tick();
    bus_if.smpl_vld = 1'b0;
    chk("drop_wr",  int'(bus_if.wr_ptr), 2);
    chk("drop_ovr", int'(bus_if.overrun), 1);
`ifdef FIR_SEQ_DROP_CNT_EN
    chk("drop_cnt1", int'(bus_if.drop_cnt), 1);
`endif
    bus_if.smpl_vld = 1'b1;
    bus_if.clr_err  = 1'b1;
    tick();
    bus_if.smpl_vld = 1'b0;
    bus_if.clr_err  = 1'b0;
    chk("clrdrop_ovr", int'(bus_if.overrun), 1);
`ifdef FIR_SEQ_DROP_CNT_EN
    chk("clrdrop_cnt", int'(bus_if.drop_cnt), 1);
`endif
    wait_idle();
    bus_if.clr_err = 1'b1;
    tick();
    bus_if.clr_err = 1'b0;
    chk("clr_ovr", int'(bus_if.overrun), 0);
`ifdef FIR_SEQ_DROP_CNT_EN
    chk("clr_cnt", int'(bus_if.drop_cnt), 0);
`endif

    // Reset in the second burst cycle.
    pulse(2, "p9");
    tick();
    rst = 1'b1;
    #1;
    chk("arst_seq",  int'(bus_if.sequencing), 0);
    chk("arst_busy", int'(bus_if.busy), 0);
    chk("arst_ovld", int'(bus_if.out_vld), 0);
    chk("arst_rd",   int'(bus_if.rd_ptr), 0);
    chk("arst_wr",   int'(bus_if.wr_ptr), 0);
    chk("arst_full", int'(bus_if.full), 0);
    chk("arst_ovr",  int'(bus_if.overrun), 0);
    tick();
    rst = 1'b0;
    pulse(0, "r1"); tick(); chk("r1_busy", int'(bus_if.busy), 0);
    pulse(1, "r2"); tick(); chk("r2_busy", int'(bus_if.busy), 0);
    pulse(2, "r3"); tick(); chk("r3_busy", int'(bus_if.busy), 0);
    pulse(3, "r4");
    check_burst('{0, 1, 2, 3}, "rb");

    // Random traffic with clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bus_if.smpl_vld = ($urandom_range(0, 3) == 0);
      bus_if.clr_err  = ($urandom_range(0, 15) == 0);
      rst             = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst            = 1'b0;
    bus_if.clr_err = 1'b0;
    // Heavy traffic without clears to drive the drop counter to saturation.
    for (int i = 0; i < 2000; i++) begin
      bus_if.smpl_vld = ($urandom_range(0, 1) == 0);
      tick();
    end
    bus_if.smpl_vld = 1'b0;
    repeat (10) tick();

    done = 1'b1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
